// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction-fetch responder: grants address phases, reads a synchronous
// word-addressed SRAM and returns in-order rvalid/rdata/err responses with a
// bounded number of outstanding transactions, optional response back-pressure
// and optional LFSR-driven grant stalls.

// Protocol checker: the response queue must never be written while full.
module cv32e40p_obi_instr_responder_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  no_push_when_full_a : assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

module cv32e40p_obi_instr_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          GNT_STALL_EN    = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  localparam int unsigned AW             = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          obi_req_i,
  output logic          obi_gnt_o,
  input  logic [31:0]   obi_addr_i,
  output logic          obi_rvalid_o,
  output logic [31:0]   obi_rdata_o,
  output logic          obi_err_o,
  input  logic          resp_stall_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  // Fibonacci LFSR step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Circular pointer increment that wraps at the queue depth.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  logic [15:0]   lfsr_r;
  logic [CW-1:0] cnt_r;
  logic          pend_valid_r;
  logic          pend_err_r;
  logic [32:0]   q_mem_r [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] q_cnt_r;

  logic [29:0]   word_s;
  logic          in_range_s;
  logic          stall_s;
  logic          gnt_s;
  logic          hs_s;
  logic          q_empty_s;
  logic          q_full_s;
  logic [31:0]   res_data_s;
  logic          fall_s;
  logic          pop_s;
  logic          push_s;
  logic          rvalid_s;
  logic [32:0]   head_s;
  logic          unused_s;

  assign word_s     = obi_addr_i[31:2];
  assign unused_s   = ^obi_addr_i[1:0];
  assign in_range_s = (word_s < 30'(MEM_WORDS));
  assign stall_s    = GNT_STALL_EN && (lfsr_r[1:0] == 2'b00);
  // No same-cycle slot reuse: the grant looks only at the registered count.
  assign gnt_s      = !rst && obi_req_i && (cnt_r < MAX_CNT) && !stall_s;
  assign hs_s       = obi_req_i && gnt_s;

  assign q_empty_s  = (q_cnt_r == {CW{1'b0}});
  assign q_full_s   = (q_cnt_r == MAX_CNT);
  assign res_data_s = pend_err_r ? 32'h0000_0000 : mem_rdata_i;
  assign fall_s     = pend_valid_r && q_empty_s && !resp_stall_i;
  assign pop_s      = !q_empty_s && !resp_stall_i;
  assign push_s     = pend_valid_r && !fall_s;
  assign rvalid_s   = !rst && (pop_s || fall_s);
  assign head_s     = q_mem_r[rd_ptr_r];

  assign obi_gnt_o  = gnt_s;
  assign mem_req_o  = hs_s && in_range_s;
  assign mem_addr_o = word_s[AW-1:0];

  // Response mux: queue head first, otherwise the fall-through entry; zero when idle.
  always_comb begin
    obi_rvalid_o = rvalid_s;
    obi_rdata_o  = 32'h0000_0000;
    obi_err_o    = 1'b0;
    if (rvalid_s) begin
      if (!q_empty_s) begin
        obi_err_o   = head_s[32];
        obi_rdata_o = head_s[31:0];
      end else begin
        obi_err_o   = pend_err_r;
        obi_rdata_o = res_data_s;
      end
    end else begin
      obi_rdata_o = 32'h0000_0000;
    end
  end

  // Control state: LFSR, outstanding count, pending entry, queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r       <= LFSR_SEED;
      cnt_r        <= {CW{1'b0}};
      pend_valid_r <= 1'b0;
      pend_err_r   <= 1'b0;
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      q_cnt_r      <= {CW{1'b0}};
    end else begin
      lfsr_r       <= lfsr_next(lfsr_r);
      pend_valid_r <= hs_s;
      pend_err_r   <= hs_s && !in_range_s;
      case ({hs_s, rvalid_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   q_cnt_r <= q_cnt_r + CW'(1);
        2'b01:   q_cnt_r <= q_cnt_r - CW'(1);
        default: q_cnt_r <= q_cnt_r;
      endcase
    end
  end

  // Queue storage: resolved entries are written at the tail.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      q_mem_r[wr_ptr_r] <= {pend_err_r, res_data_s};
    end
  end

  cv32e40p_obi_instr_responder_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .full (q_full_s)
  );

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Self-checking bench: directed OBI fetch sequences on a non-stalling instance
// and a random-request run on an LFSR-stalling instance, with a response
// scoreboard per instance fed from the bench's own SRAM contents.
module tb_cv32e40p_obi_instr_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, gnt0, rvalid0, err0, stall0, mreq0;
  logic [31:0] addr0, rdata0, mrdata0;
  logic [9:0]  maddr0;
  logic        req1, gnt1, rvalid1, err1, stall1, mreq1;
  logic [31:0] addr1, rdata1, mrdata1;
  logic [9:0]  maddr1;

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];

  int    checks   = 0;
  int    failures = 0;
  int    hs1      = 0;
  int    rets1    = 0;
  logic  chk0, chk1;
  resp_t exp0[$];
  resp_t exp1[$];
  logic [15:0] lfsr_m;

  cv32e40p_obi_instr_responder #(
    .MEM_WORDS(1024), .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b0), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .rst(rst), .obi_req_i(req0), .obi_gnt_o(gnt0), .obi_addr_i(addr0),
    .obi_rvalid_o(rvalid0), .obi_rdata_o(rdata0), .obi_err_o(err0),
    .resp_stall_i(stall0), .mem_req_o(mreq0), .mem_addr_o(maddr0), .mem_rdata_i(mrdata0)
  );

  cv32e40p_obi_instr_responder #(
    .MEM_WORDS(1024), .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b1), .LFSR_SEED(16'hACE1)
  ) dut1 (
    .clk(clk), .rst(rst), .obi_req_i(req1), .obi_gnt_o(gnt1), .obi_addr_i(addr1),
    .obi_rvalid_o(rvalid1), .obi_rdata_o(rdata1), .obi_err_o(err1),
    .resp_stall_i(stall1), .mem_req_o(mreq1), .mem_addr_o(maddr1), .mem_rdata_i(mrdata1)
  );

  // Synchronous SRAM models: data one cycle after the read enable.
  always @(posedge clk) begin
    if (mreq0) mrdata0 <= mem0[maddr0];
    if (mreq1) mrdata1 <= mem1[maddr1];
  end

  // Reference LFSR: x^16+x^14+x^13+x^11, shifting every non-reset cycle.
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t model(input logic [31:0] a, input int which);
    resp_t r;
    logic [29:0] w;
    w = a[31:2];
    if (w < 30'd1024) begin
      r.err  = 1'b0;
      r.data = (which == 0) ? mem0[w[9:0]] : mem1[w[9:0]];
    end else begin
      r.err  = 1'b0 + 1'b1;
      r.data = 32'h0000_0000;
    end
    return r;
  endfunction

  // One clock cycle: settle, check, run both scoreboards, advance.
  task automatic cyc(input logic eg, input logic erv, input logic emr, input string tag);
    resp_t e;
    #2;
    if (chk0) begin
      chk({tag, " gnt"}, 32'(gnt0), 32'(eg));
      chk({tag, " rvalid"}, 32'(rvalid0), 32'(erv));
      chk({tag, " mem_req"}, 32'(mreq0), 32'(emr));
    end
    if (chk1) chk("lfsr_gnt", 32'(gnt1), 32'(req1 && (lfsr_m[1:0] != 2'b00)));
    if (rst) begin
      exp0.delete();
      exp1.delete();
    end
    if (rvalid0) begin
      checks++;
      assert (exp0.size() != 0) else begin
        failures++;
        $error("FAIL dut0_unexpected_rvalid observed=rvalid expected=no_response");
      end
      if (exp0.size() != 0) begin
        e = exp0.pop_front();
        chk("dut0 rdata", rdata0, e.data);
        chk("dut0 err", 32'(err0), 32'(e.err));
      end
    end else begin
      chk("dut0 idle rdata/err", {rdata0[30:0], err0}, 32'h0);
    end
    if (rvalid1) begin
      checks++;
      assert (exp1.size() != 0) else begin
        failures++;
        $error("FAIL dut1_unexpected_rvalid observed=rvalid expected=no_response");
      end
      if (exp1.size() != 0) begin
        e = exp1.pop_front();
        rets1++;
        chk("dut1 rdata", rdata1, e.data);
        chk("dut1 err", 32'(err1), 32'(e.err));
      end
    end
    if (req0 && gnt0) begin
      exp0.push_back(model(addr0, 0));
      if (mreq0) chk("dut0 mem_addr", 32'(maddr0), 32'(addr0[11:2]));
    end
    if (req1 && gnt1) begin
      exp1.push_back(model(addr1, 1));
      hs1++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int w;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0001;
      mem1[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0000_9E37);
    end
    rst = 1'b1; chk0 = 1'b1; chk1 = 1'b0;
    req0 = 1'b1; addr0 = 32'h0; stall0 = 1'b0;
    req1 = 1'b0; addr1 = 32'h0; stall1 = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    // Back-to-back fetches, latency 1.
    addr0 = 32'h0; cyc(1'b1, 1'b0, 1'b1, "t1 c0");
    addr0 = 32'h4; cyc(1'b1, 1'b1, 1'b1, "t1 c1");
    addr0 = 32'h8; cyc(1'b1, 1'b1, 1'b1, "t1 c2");
    req0 = 1'b0;   cyc(1'b0, 1'b1, 1'b0, "t1 c3");
    cyc(1'b0, 1'b0, 1'b0, "t1 idle");

    // Back-pressure until the outstanding limit, then release.
    stall0 = 1'b1; req0 = 1'b1;
    addr0 = 32'hC;  cyc(1'b1, 1'b0, 1'b1, "t2 g1");
    addr0 = 32'h10; cyc(1'b1, 1'b0, 1'b1, "t2 g2");
    addr0 = 32'h14; cyc(1'b0, 1'b0, 1'b0, "t2 full a");
    cyc(1'b0, 1'b0, 1'b0, "t2 full b");
    stall0 = 1'b0;  cyc(1'b0, 1'b1, 1'b0, "t2 release");
    cyc(1'b1, 1'b1, 1'b1, "t2 third gnt");
    req0 = 1'b0;    cyc(1'b0, 1'b1, 1'b0, "t2 third rsp");
    cyc(1'b0, 1'b0, 1'b0, "t2 idle");

    // Out-of-range and boundary addresses mixed with in-range ones.
    req0 = 1'b1;
    addr0 = 32'h0000_1000; cyc(1'b1, 1'b0, 1'b0, "t3 oor");
    addr0 = 32'h0000_0FFC; cyc(1'b1, 1'b1, 1'b1, "t3 last");
    addr0 = 32'h8000_0004; cyc(1'b1, 1'b1, 1'b0, "t3 high");
    addr0 = 32'h0000_001B; cyc(1'b1, 1'b1, 1'b1, "t3 byteoff");
    req0 = 1'b0;           cyc(1'b0, 1'b1, 1'b0, "t3 tail");
    cyc(1'b0, 1'b0, 1'b0, "t3 idle");

    // Full count with rvalid in the same cycle: no grant until the next cycle.
    stall0 = 1'b1; req0 = 1'b1;
    addr0 = 32'h20; cyc(1'b1, 1'b0, 1'b1, "t4 g1");
    addr0 = 32'h24; cyc(1'b1, 1'b0, 1'b1, "t4 g2");
    stall0 = 1'b0; addr0 = 32'h28; cyc(1'b0, 1'b1, 1'b0, "t4 full rvalid");
    cyc(1'b1, 1'b1, 1'b1, "t4 gnt next");
    req0 = 1'b0;    cyc(1'b0, 1'b1, 1'b0, "t4 r3");
    cyc(1'b0, 1'b0, 1'b0, "t4 idle");

    // Reset with two transactions outstanding, one SRAM read in flight.
    stall0 = 1'b1; req0 = 1'b1;
    addr0 = 32'h2C; cyc(1'b1, 1'b0, 1'b1, "t5 g1");
    addr0 = 32'h30; cyc(1'b1, 1'b0, 1'b1, "t5 g2");
    req0 = 1'b0; rst = 1'b1; cyc(1'b0, 1'b0, 1'b0, "t5 rst");
    rst = 1'b0; stall0 = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, "t5 dropped a");
    cyc(1'b0, 1'b0, 1'b0, "t5 dropped b");
    req0 = 1'b1; addr0 = 32'h34; cyc(1'b1, 1'b0, 1'b1, "t5 fresh");
    req0 = 1'b0; cyc(1'b0, 1'b1, 1'b0, "t5 latency1");
    cyc(1'b0, 1'b0, 1'b0, "t5 idle");
    chk("t5 drained", 32'(exp0.size()), 32'd0);

    // Random requests against the LFSR-stalling instance.
    chk0 = 1'b0; chk1 = 1'b1;
    n = 0;
    while (hs1 < 200 && n < 3000) begin
      req1 = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1023);
      if ($urandom_range(0, 9) == 0) addr1 = 32'h0000_1000 + (32'(w) << 2);
      else                           addr1 = (32'(w) << 2) | 32'($urandom_range(0, 3));
      cyc(1'b0, 1'b0, 1'b0, "t6");
      n++;
    end
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, "t6 drain");
    chk("t6 handshakes", 32'(hs1), 32'd200);
    chk("t6 responses", 32'(rets1), 32'd200);
    chk("t6 drained", 32'(exp1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
